div_stall_unit: RTL and testbench
=================================

DIV_STALL_UNIT -- requirements
Module: DivStallUnit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width; counter width is clog2(XLEN)+1.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-004 SHALL have port enable  input  1  EX stage holds a divide/remainder op; held high by EX while stalled.
REQ-005 SHALL have port command  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-006 SHALL have port srcA  input  XLEN  dividend.
REQ-007 SHALL have port srcB  input  XLEN  divisor.
REQ-008 SHALL have port flush  input  1  pipeline flush from the pipeline controller; aborts any operation.
REQ-009 SHALL have port stallReq  output  1  EX stall request, driven to the pipeline controller as exStallReq.
REQ-010 SHALL have port done  output  1  result valid this cycle; EX may retire the op.
REQ-011 SHALL have port result  output  XLEN  quotient or remainder per command.

Function
REQ-012 SHALL use FSM states IDLE, BUSY and DONE.
REQ-013 In IDLE with enable=1 and flush=0, SHALL latch command, |srcA|, |srcB| and the sign info, and SHALL go to BUSY with counter=0.
REQ-014 In IDLE with enable=1 and flush=0, SHALL drive stallReq=1 combinationally in that same cycle.
REQ-015 In BUSY, SHALL perform one radix-2 restoring step per cycle and increment the counter.
REQ-016 SHALL go from BUSY to DONE after XLEN steps (counter = XLEN-1 step).
REQ-017 SHALL hold stallReq=1 throughout BUSY.
REQ-018 In DONE, SHALL drive stallReq=0 and done=1 with the final result.
REQ-019 SHALL go from DONE to IDLE unconditionally; enable still high in DONE SHALL NOT restart an operation.
REQ-020 SHALL make the latency for normal ops: start cycle T, stallReq=1 for cycles T..T+XLEN, done=1 at T+XLEN+1.
REQ-021 DIV/REM SHALL be signed: quotient negated when the operand signs differ; remainder takes the sign of the dividend.
REQ-022 DIVU/REMU SHALL be unsigned.
REQ-023 Divisor=0 SHALL give quotient all-ones and remainder = srcA.
REQ-024 On divisor=0, SHALL skip BUSY and go IDLE->DONE; stallReq=1 only in the start cycle.
REQ-025 Signed overflow (srcA=0x80000000, srcB=0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000 and remainder 0.
REQ-026 On signed overflow, SHALL go IDLE->DONE with the same single-cycle stall as divide-by-zero.
REQ-027 flush=1 in any state SHALL force stallReq=0 and done=0 combinationally, and SHALL put the FSM in IDLE next cycle.
REQ-028 flush=1 together with enable=1 in IDLE SHALL NOT start an operation.
REQ-029 SHALL drive result=0 whenever done=0.
REQ-030 SHALL perform all arithmetic at XLEN+1 bits internally; result SHALL be truncated to XLEN.

Reset
REQ-031 rst=0 SHALL asynchronously set state=IDLE, counter=0, and clear all operand and partial-result registers.
REQ-032 During reset, outputs SHALL be stallReq=0, done=0, result=0.
REQ-033 Reset asserted mid-BUSY SHALL abandon the operation; after release, the unit SHALL be IDLE with no spurious done.

Verification
REQ-034 SHALL test DIVU 100/7: stallReq high 33 cycles, then done=1 with result=14; REMU 100/7 gives 2.
REQ-035 SHALL test DIV -7/2: result 0xFFFFFFFD; REM -7/2 gives result 0xFFFFFFFF.
REQ-036 SHALL test DIVU 5/0: one stall cycle, next cycle done=1 with result=0xFFFFFFFF; REMU 5/0 gives 5.
REQ-037 SHALL test DIV 0x80000000/0xFFFFFFFF: one stall cycle, then result=0x80000000; REM gives 0.
REQ-038 SHALL test flush=1 at BUSY step 10: stallReq=0 that cycle, IDLE next cycle, done never asserted.
REQ-039 SHALL test enable held high through DONE: exactly one done pulse, IDLE afterwards; a fresh enable later starts a new op.

Source files
------------

// File: rtl/div_stall_unit_if.sv
// Handshake bundle between the EX stage (master) and the multi-cycle divider (slave).
// stallReq feeds the pipeline controller's exStallReq input.
interface div_stall_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            enable;
  logic [1:0]      command;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            flush;
  logic            stallReq;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output enable, command, srcA, srcB, flush,
    input  stallReq, done, result
  );

  modport slave (
    input  enable, command, srcA, srcB, flush,
    output stallReq, done, result
  );
endinterface

// File: rtl/div_stall_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU that stalls EX while busy.
// Divide-by-zero and signed overflow bypass the iteration and finish after one stall cycle.
module div_stall_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  div_stall_unit_if.slave  bus_io
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN:0]   dvs_q, dvs_d;
  logic            is_rem_q, is_rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;

  logic          is_signed, a_neg, b_neg, div_zero, overflow, start;
  logic [XLEN:0] a_ext, b_ext, a_abs, b_abs;
  logic [XLEN:0] shifted, diff;
  logic [XLEN:0] quo_fix, rem_fix, res_wide;
  logic          unused_bits;

  always_comb begin
    is_signed = ~bus_io.command[0];
    a_ext     = {is_signed & bus_io.srcA[XLEN-1], bus_io.srcA};
    b_ext     = {is_signed & bus_io.srcB[XLEN-1], bus_io.srcB};
    a_neg     = a_ext[XLEN];
    b_neg     = b_ext[XLEN];
    a_abs     = a_neg ? -a_ext : a_ext;
    b_abs     = b_neg ? -b_ext : b_ext;
    div_zero  = (bus_io.srcB == '0);
    overflow  = is_signed && (bus_io.srcA == MinNeg) && (bus_io.srcB == '1);
    start     = (state_q == StIdle) && bus_io.enable && !bus_io.flush;
    // One restoring step: shift in the next dividend bit, subtract if it fits.
    shifted   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    diff      = shifted - dvs_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_rem_d = bus_io.command[1];
          cnt_d    = '0;
          if (div_zero) begin
            quo_d   = '1;
            rem_d   = {1'b0, bus_io.srcA};
            dvs_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = StDone;
          end else if (overflow) begin
            quo_d   = MinNeg;
            rem_d   = '0;
            dvs_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = StDone;
          end else begin
            quo_d   = a_abs[XLEN-1:0];
            rem_d   = '0;
            dvs_d   = b_abs;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (diff[XLEN]) begin
          rem_d = shifted;
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
          rem_d = diff;
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (bus_io.flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

  always_comb begin
    quo_fix  = q_neg_q ? -{1'b0, quo_q} : {1'b0, quo_q};
    rem_fix  = r_neg_q ? -rem_q : rem_q;
    res_wide = is_rem_q ? rem_fix : quo_fix;
    // rst gates stallReq so a held enable cannot raise it while in reset.
    bus_io.stallReq = rst && !bus_io.flush &&
                      ((state_q == StBusy) || ((state_q == StIdle) && bus_io.enable));
    bus_io.done     = (state_q == StDone) && !bus_io.flush;
    bus_io.result   = bus_io.done ? res_wide[XLEN-1:0] : '0;
    unused_bits     = ^{res_wide[XLEN], a_abs[XLEN]};
  end

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed and randomized checks of div_stall_unit against an arithmetic reference model.
module tb_div_stall_unit;

  localparam logic [31:0] MinNeg = 32'h8000_0000;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_stall_unit_if #(.XLEN(32)) bus ();

  div_stall_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the arithmetic rules.
  function automatic logic [31:0] ref_res(input logic [1:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return cmd[1] ? a : 32'hFFFF_FFFF;
    if (!cmd[0] && a == MinNeg && b == 32'hFFFF_FFFF) return cmd[1] ? 32'd0 : MinNeg;
    case (cmd)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_stall(input logic [1:0] cmd, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!cmd[0] && a == MinNeg && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Runs one op with enable held through DONE, then drops enable in the following IDLE cycle.
  task automatic run_op(input string tag, input logic [1:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
    int          stall_cnt;
    bit          got_done;
    logic [31:0] res;
    stall_cnt = 0;
    got_done  = 1'b0;
    res       = '0;
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.command = cmd;
    bus.srcA    = a;
    bus.srcB    = b;
    for (int i = 0; i < 100 && !got_done; i++) begin
      #1;
      if (bus.done) begin
        got_done = 1'b1;
        res      = bus.result;
        check({tag, " stall_in_done"}, 32'(bus.stallReq), 32'd0);
      end else begin
        if (bus.stallReq) stall_cnt++;
        @(negedge clk);
      end
    end
    check({tag, " done_seen"}, 32'(got_done), 32'd1);
    check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    check({tag, " result"}, res, exp_res);
    @(posedge clk);
    #1;
    check({tag, " done_after"}, 32'(bus.done), 32'd0);
    bus.enable = 1'b0;
    #1;
    check({tag, " idle_after"}, 32'(bus.stallReq), 32'd0);
    check({tag, " result_after"}, bus.result, 32'd0);
  endtask

  initial begin
    int          done_cnt;
    int          busy_cnt;
    logic [1:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    int          mode;

    rst         = 1'b0;
    bus.enable  = 1'b0;
    bus.command = 2'd0;
    bus.srcA    = '0;
    bus.srcB    = '0;
    bus.flush   = 1'b0;
    #1;
    check("reset stallReq", 32'(bus.stallReq), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu_5_0", 2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 2'd0, MinNeg, 32'hFFFF_FFFF, MinNeg, 1);
    run_op("rem_ovf", 2'd2, MinNeg, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush at BUSY step 10: start cycle T, counter reaches 10 in cycle T+11.
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.command = 2'd1;
    bus.srcA    = 32'd1000;
    bus.srcB    = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    check("flush busy_before", 32'(bus.stallReq), 32'd1);
    bus.flush = 1'b1;
    #1;
    check("flush stallReq", 32'(bus.stallReq), 32'd0);
    check("flush done", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.flush  = 1'b0;
    bus.enable = 1'b0;
    #1;
    check("flush idle_next", 32'(bus.stallReq), 32'd0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    check("flush no_done", 32'(done_cnt), 32'd0);

    // flush together with enable in IDLE must not start anything.
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.flush   = 1'b1;
    bus.command = 2'd0;
    bus.srcA    = 32'd77;
    bus.srcB    = 32'd5;
    #1;
    check("flush_en stallReq", 32'(bus.stallReq), 32'd0);
    @(negedge clk);
    bus.enable = 1'b0;
    bus.flush  = 1'b0;
    #1;
    check("flush_en no_start", 32'(bus.stallReq), 32'd0);

    // Reset mid-BUSY with enable still asserted.
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.command = 2'd0;
    bus.srcA    = 32'd12345;
    bus.srcB    = 32'd17;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid stallReq", 32'(bus.stallReq), 32'd0);
    check("rst_mid done", 32'(bus.done), 32'd0);
    check("rst_mid result", bus.result, 32'd0);
    @(negedge clk);
    bus.enable = 1'b0;
    rst        = 1'b1;
    done_cnt   = 0;
    busy_cnt   = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.done) done_cnt++;
      if (bus.stallReq) busy_cnt++;
    end
    check("rst_mid no_done", 32'(done_cnt), 32'd0);
    check("rst_mid idle", 32'(busy_cnt), 32'd0);

    // Fresh op after the disturbances, then randomized ops.
    run_op("fresh_div", 2'd0, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 33);
    for (int k = 0; k < 16; k++) begin
      cmd  = 2'($urandom_range(0, 3));
      a    = $urandom;
      mode = int'($urandom_range(0, 7));
      case (mode)
        0:       b = 32'd0;
        1: begin a = MinNeg; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", k), cmd, a, b, ref_res(cmd, a, b), ref_stall(cmd, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
